pulp_run_ctrl: RTL and testbench

Run controller between the PS7 fetch-enable/status registers and the PULPino SoC plus clk_rst_gen. Converts the PS7 `fetch_enable` word into a sequenced PULP reset release and a debounced `fetch_en`. Synchronises the SoC's `eoc`/`return` back into the PS7 clock domain. Assembles the `end_of_operation` status word, which includes a run-cycle counter and an optional watchdog timeout. Runs entirely in the PS7 clock domain.

---
 rtl/pulp_run_ctrl_if.sv | 21 ++
 rtl/pulp_run_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pulp_run_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pulp_run_ctrl_if.sv
// Signal bundle between the PS7 control/status registers and the run controller.
interface pulp_run_ctrl_if;
  logic [31:0] fetch_enable_i;
  logic        eoc_i;
  logic [1:0]  return_i;
  logic        pulp_rst_no;
  logic        fetch_en_o;
  logic [31:0] end_of_operation_o;

  // PS7 side: drives the control word and sees the SoC status.
  modport master (
    output fetch_enable_i, eoc_i, return_i,
    input  pulp_rst_no, fetch_en_o, end_of_operation_o
  );

  // Controller side.
  modport slave (
    input  fetch_enable_i, eoc_i, return_i,
    output pulp_rst_no, fetch_en_o, end_of_operation_o
  );
endinterface

// File: rtl/pulp_run_ctrl.sv
// PULPino run controller: sequenced reset release, debounced fetch enable,
// eoc/return synchronisation and the end_of_operation status word.
module pulp_run_ctrl #(
  parameter int unsigned DEB_CYCLES     = 16,
  parameter int unsigned RST_CYCLES     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  pulp_run_ctrl_if.slave   bus
);

  localparam int unsigned DEB_W = 6;
  localparam int unsigned RST_W = 8;
  localparam int unsigned CNT_W = 24;

  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam bit               TOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TOUT_LAST = TOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    HOLD_RST, RELEASE, ARMED, RUN, DONE, TOUT
  } state_e;

  logic             eoc_meta_q, eoc_s_q;
  logic [1:0]       ret_meta_q, ret_s_q;
  logic             deb_q, deb_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             armed_q, armed_d;
  state_e           state_q, state_d;
  logic [RST_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             eoc_q, eoc_d;
  logic             tout_q, tout_d;
  logic [1:0]       ret_q, ret_d;
  logic             rst_no_q, run_q;

  logic fetch_req, pulp_rel;
  logic unused_fe;

  assign fetch_req = bus.fetch_enable_i[0];
  assign pulp_rel  = bus.fetch_enable_i[31];
  assign unused_fe = ^bus.fetch_enable_i[30:1];

  // Two-flop synchroniser for the SoC-domain eoc/return.
  always_ff @(posedge clk) begin
    if (rst) begin
      eoc_meta_q <= 1'b0;
      eoc_s_q    <= 1'b0;
      ret_meta_q <= 2'b00;
      ret_s_q    <= 2'b00;
    end else begin
      eoc_meta_q <= bus.eoc_i;
      eoc_s_q    <= eoc_meta_q;
      ret_meta_q <= bus.return_i;
      ret_s_q    <= ret_meta_q;
    end
  end

  // Fetch-request debouncer: accept a new level after DEB_CYCLES stable samples.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (fetch_req != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d = fetch_req;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  // Next state, wait/run counters and status fields.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cyc_d   = cyc_q;
    eoc_d   = eoc_q;
    tout_d  = tout_q;
    ret_d   = ret_q;
    // A request must be seen low after a run starts before another run may
    // begin, so an aborted run cannot restart on a stale request.
    armed_d = armed_q | ~deb_q;

    if (!pulp_rel) begin
      state_d = HOLD_RST;
    end else begin
      case (state_q)
        HOLD_RST: begin
          state_d = RELEASE;
          wait_d  = '0;
        end
        RELEASE: begin
          if (wait_q == RST_LAST) begin
            state_d = ARMED;
          end else begin
            wait_d = wait_q + RST_W'(1);
          end
        end
        ARMED: begin
          if (deb_q && armed_q) begin
            state_d = RUN;
            cyc_d   = '0;
            eoc_d   = 1'b0;
            tout_d  = 1'b0;
            ret_d   = 2'b00;
            armed_d = 1'b0;
          end
        end
        RUN: begin
          if (eoc_s_q) begin
            state_d = DONE;
            eoc_d   = 1'b1;
            ret_d   = ret_s_q;
          end else if (TOUT_EN && (cyc_q == TOUT_LAST)) begin
            state_d = TOUT;
            tout_d  = 1'b1;
          end else if (cyc_q != '1) begin
            cyc_d = cyc_q + CNT_W'(1);
          end
        end
        DONE, TOUT: begin
          if (!deb_q) begin
            state_d = ARMED;
          end
        end
        default: state_d = HOLD_RST;
      endcase
    end
  end

  // State, debouncer, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HOLD_RST;
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
      armed_q   <= 1'b0;
      wait_q    <= '0;
      cyc_q     <= '0;
      eoc_q     <= 1'b0;
      tout_q    <= 1'b0;
      ret_q     <= 2'b00;
      rst_no_q  <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      armed_q   <= armed_d;
      wait_q    <= wait_d;
      cyc_q     <= cyc_d;
      eoc_q     <= eoc_d;
      tout_q    <= tout_d;
      ret_q     <= ret_d;
      rst_no_q  <= (state_d != HOLD_RST);
      run_q     <= (state_d == RUN);
    end
  end

  assign bus.pulp_rst_no        = rst_no_q;
  assign bus.fetch_en_o         = run_q;
  assign bus.end_of_operation_o = {cyc_q, 3'b000, run_q, tout_q, ret_q, eoc_q};

endmodule

// File: tb/tb_pulp_run_ctrl.sv
// Bench for pulp_run_ctrl: vector table, directed corner sequences and a
// randomized phase compared against a behavioural model.
module tb_pulp_run_ctrl;

  localparam int unsigned DEB  = 16;
  localparam int unsigned RSTC = 32;
  localparam int unsigned TOUT = 1000;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pulp_run_ctrl_if bus();

  pulp_run_ctrl #(
    .DEB_CYCLES    (DEB),
    .RST_CYCLES    (RSTC),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- behavioural reference model ----------------
  typedef enum {P_OFF, P_WAIT, P_IDLE, P_GO, P_END} phase_t;

  phase_t     ph;
  int         wait_n, run_n, diff_n;
  bit         lvl, fresh;
  bit         s_eoc, s_tout;
  bit [1:0]   s_ret;
  bit         q_eoc[$];
  bit [1:0]   q_ret[$];

  function void model_reset();
    ph = P_OFF; wait_n = 0; run_n = 0; diff_n = 0;
    lvl = 1'b0; fresh = 1'b0;
    s_eoc = 1'b0; s_tout = 1'b0; s_ret = 2'b00;
    q_eoc.delete(); q_ret.delete();
  endfunction

  // One clock edge of the reference behaviour.
  function void model_step();
    bit          old_lvl, e_now, raw;
    bit [1:0]    r_now;
    logic [31:0] fe;
    if (rst) begin
      model_reset();
      return;
    end
    fe      = bus.fetch_enable_i;
    raw     = fe[0];
    old_lvl = lvl;
    // the controller reacts to eoc/return as they were two samples ago
    e_now = (q_eoc.size() == 2) ? q_eoc[0] : 1'b0;
    r_now = (q_ret.size() == 2) ? q_ret[0] : 2'b00;
    q_eoc.push_back(bus.eoc_i);
    q_ret.push_back(bus.return_i);
    if (q_eoc.size() > 2) void'(q_eoc.pop_front());
    if (q_ret.size() > 2) void'(q_ret.pop_front());
    // accepted level changes once the raw value has differed DEB times running
    if (raw != lvl) begin
      diff_n++;
      if (diff_n == int'(DEB)) begin
        lvl = raw;
        diff_n = 0;
      end
    end else begin
      diff_n = 0;
    end
    if (!fe[31]) begin
      ph = P_OFF;
    end else begin
      case (ph)
        P_OFF:  begin ph = P_WAIT; wait_n = 0; end
        P_WAIT: if (wait_n == int'(RSTC) - 1) ph = P_IDLE; else wait_n++;
        P_IDLE: if (old_lvl && fresh) begin
                  ph = P_GO; run_n = 0;
                  s_eoc = 1'b0; s_tout = 1'b0; s_ret = 2'b00; fresh = 1'b0;
                end
        P_GO:   if (e_now) begin
                  ph = P_END; s_eoc = 1'b1; s_ret = r_now;
                end else if (TOUT != 0 && run_n == int'(TOUT) - 1) begin
                  ph = P_END; s_tout = 1'b1;
                end else if (run_n < 24'hFFFFFF) begin
                  run_n++;
                end
        P_END:  if (!old_lvl) ph = P_IDLE;
        default: ;
      endcase
    end
    if (!old_lvl) fresh = 1'b1;
  endfunction

  function logic [31:0] m_status();
    return {24'(run_n), 3'b000, (ph == P_GO), s_tout, s_ret, s_eoc};
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input logic r, input logic [31:0] fe, input logic e, input logic [1:0] rc);
    rst                = r;
    bus.fetch_enable_i = fe;
    bus.eoc_i          = e;
    bus.return_i       = rc;
  endtask

  task automatic check(input string name, input logic rstn, input logic fen, input logic [31:0] sts);
    checks++;
    if (bus.pulp_rst_no !== rstn || bus.fetch_en_o !== fen || bus.end_of_operation_o !== sts) begin
      errors++;
      $display("FAIL %s: got rst_no=%b fetch_en=%b status=%h, want rst_no=%b fetch_en=%b status=%h",
               name, bus.pulp_rst_no, bus.fetch_en_o, bus.end_of_operation_o, rstn, fen, sts);
    end
  endtask

  task automatic seq(input string name, input int n, input logic rstn, input logic fen, input logic [31:0] sts);
    run(n);
    check(name, rstn, fen, sts);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        r;
    logic [31:0] fe;
    logic        eoc;
    logic [1:0]  ret;
    int          n;
    logic        rstn;
    logic        fen;
    logic [31:0] sts;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic        b0, b31;
    int          hold0, drop31, eoc_left;
    logic [1:0]  rc;
    logic [31:0] junk, fe;
    logic        r;

    drive(1'b1, 32'h0, 1'b0, 2'b00);
    model_reset();

    // boot, normal run with eoc/return, debounce glitches
    tbl[0]  = '{1'b1, 32'h0000_0000, 1'b0, 2'b00,  3, 1'b0, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b0, 32'h8000_0000, 1'b0, 2'b00,  1, 1'b1, 1'b0, 32'h0000_0000};
    tbl[2]  = '{1'b0, 32'h8000_0000, 1'b0, 2'b00, 31, 1'b1, 1'b0, 32'h0000_0000};
    tbl[3]  = '{1'b0, 32'h8000_0001, 1'b0, 2'b00, 16, 1'b1, 1'b0, 32'h0000_0000};
    tbl[4]  = '{1'b0, 32'h8000_0001, 1'b0, 2'b00,  1, 1'b1, 1'b1, 32'h0000_0010};
    tbl[5]  = '{1'b0, 32'h8000_0001, 1'b0, 2'b00, 99, 1'b1, 1'b1, 32'h0000_6310};
    tbl[6]  = '{1'b0, 32'h8000_0001, 1'b1, 2'b10,  1, 1'b1, 1'b1, 32'h0000_6410};
    tbl[7]  = '{1'b0, 32'h8000_0001, 1'b1, 2'b10,  1, 1'b1, 1'b1, 32'h0000_6510};
    tbl[8]  = '{1'b0, 32'h8000_0001, 1'b1, 2'b10,  1, 1'b1, 1'b0, 32'h0000_6505};
    tbl[9]  = '{1'b0, 32'h8000_0000, 1'b0, 2'b00, 16, 1'b1, 1'b0, 32'h0000_6505};
    tbl[10] = '{1'b0, 32'h8000_0001, 1'b0, 2'b00, 15, 1'b1, 1'b0, 32'h0000_6505};
    tbl[11] = '{1'b0, 32'h8000_0000, 1'b0, 2'b00, 15, 1'b1, 1'b0, 32'h0000_6505};
    tbl[12] = '{1'b0, 32'h8000_0001, 1'b0, 2'b00, 15, 1'b1, 1'b0, 32'h0000_6505};
    tbl[13] = '{1'b0, 32'h8000_0000, 1'b0, 2'b00,  3, 1'b1, 1'b0, 32'h0000_6505};
    tbl[14] = '{1'b0, 32'h8000_0001, 1'b0, 2'b00, 16, 1'b1, 1'b0, 32'h0000_6505};
    tbl[15] = '{1'b0, 32'h8000_0001, 1'b0, 2'b00,  1, 1'b1, 1'b1, 32'h0000_0010};

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].r, tbl[i].fe, tbl[i].eoc, tbl[i].ret);
      seq($sformatf("vec[%0d]", i), tbl[i].n, tbl[i].rstn, tbl[i].fen, tbl[i].sts);
    end

    // watchdog: run entered on the last vector, count 0
    seq("wd_before", 999, 1'b1, 1'b1, 32'h0003_E710);
    seq("wd_fire",     1, 1'b1, 1'b0, 32'h0003_E708);
    drive(1'b0, 32'h8000_0000, 1'b0, 2'b00);
    seq("tout_hold",  16, 1'b1, 1'b0, 32'h0003_E708);
    drive(1'b0, 32'h8000_0001, 1'b0, 2'b00);
    seq("rearm_wait", 16, 1'b1, 1'b0, 32'h0003_E708);
    seq("rearm_run",   1, 1'b1, 1'b1, 32'h0000_0010);

    // eoc reaching the controller on the watchdog's last cycle wins
    run(997);
    drive(1'b0, 32'h8000_0001, 1'b1, 2'b01);
    seq("race_before", 2, 1'b1, 1'b1, 32'h0003_E710);
    seq("race_done",   1, 1'b1, 1'b0, 32'h0003_E703);

    drive(1'b0, 32'h8000_0000, 1'b0, 2'b00);
    run(16);
    drive(1'b0, 32'h8000_0001, 1'b0, 2'b00);
    seq("rerun", 17, 1'b1, 1'b1, 32'h0000_0010);

    // abort mid-run, then re-release with the request still high
    run(50);
    drive(1'b0, 32'h0000_0001, 1'b0, 2'b00);
    seq("abort",      1, 1'b0, 1'b0, 32'h0000_3200);
    seq("abort_hold", 3, 1'b0, 1'b0, 32'h0000_3200);
    drive(1'b0, 32'h8000_0001, 1'b0, 2'b00);
    seq("re_release", 1, 1'b1, 1'b0, 32'h0000_3200);
    seq("stale_req", 40, 1'b1, 1'b0, 32'h0000_3200);
    drive(1'b0, 32'h8000_0000, 1'b0, 2'b00);
    run(16);
    drive(1'b0, 32'h8000_0001, 1'b0, 2'b00);
    seq("toggle_wait", 16, 1'b1, 1'b0, 32'h0000_3200);
    seq("toggle_run",   1, 1'b1, 1'b1, 32'h0000_0010);

    // synchronous reset mid-run with the control word left asserted
    run(5);
    drive(1'b1, 32'h8000_0001, 1'b0, 2'b00);
    seq("sync_rst", 1, 1'b0, 1'b0, 32'h0000_0000);
    drive(1'b0, 32'h8000_0001, 1'b0, 2'b00);
    seq("post_rst_armed", 33, 1'b1, 1'b0, 32'h0000_0000);
    seq("post_rst_run",    1, 1'b1, 1'b1, 32'h0000_0010);

    // randomized phase against the model
    b0 = 1'b1; hold0 = 0; drop31 = 0; eoc_left = 0; rc = 2'b00;
    for (int i = 0; i < 8000; i++) begin
      if (hold0 == 0) begin
        b0    = ~b0;
        hold0 = $urandom_range(1, 40);
      end
      hold0--;
      if (drop31 > 0) drop31--;
      else if ($urandom_range(0, 599) == 0) drop31 = $urandom_range(1, 4);
      b31 = (drop31 == 0);
      if (eoc_left > 0) begin
        eoc_left--;
      end else if ($urandom_range(0, 299) == 0) begin
        eoc_left = $urandom_range(1, 6);
        rc       = 2'($urandom_range(0, 3));
      end else begin
        rc = 2'($urandom_range(0, 3));
      end
      r    = ($urandom_range(0, 2999) == 0);
      junk = $urandom();
      fe   = {b31, junk[30:1], b0};
      drive(r, fe, (eoc_left > 0), rc);
      tick();
      check($sformatf("rand@%0d", i), (ph != P_OFF), (ph == P_GO), m_status());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
